// File: rtl/div.sv
// ---------------------------------------------------------------------------
// div -- multi-cycle 32-bit integer divider for the EX stage.
//
// Runs DIV (signed) and DIVU (unsigned) as a 32-iteration radix-2
// shift-subtract loop on operand magnitudes. The latched result signs are
// applied when the last iteration completes. While a division is in flight
// it holds the pipeline through stallreq_o, so start_i and the operands
// stay stable until ready_o is seen.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   start_i       EX-stage instruction is DIV/DIVU
//   signed_div_i  1 = DIV (signed), 0 = DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   annul_i       cancel the current operation (pipeline flush)
//   result_o      {remainder, quotient}, registered
//   ready_o       result_o valid this cycle, registered one-cycle pulse
//   stallreq_o    stall request to the pipeline controller, combinational
// ---------------------------------------------------------------------------
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] rem;      // partial remainder (upper half of the shift pair)
  logic [31:0] dvd;      // dividend bits shifting out, quotient bits shifting in
  logic [31:0] dvs;      // divisor magnitude
  logic        neg_q;
  logic        neg_r;

  // One shift-subtract iteration, computed from the current registers.
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        q_bit;
  logic [31:0] rem_nx;
  logic [31:0] dvd_nx;
  logic [31:0] q_fin;
  logic [31:0] r_fin;
  logic [31:0] op1_mag;
  logic [31:0] op2_mag;

  // NOTE: every signal written here gets a value on every path, so no
  // latches are inferred; combinational blocks use blocking assignments.
  always_comb begin
    shifted = {rem, dvd[31]};
    diff    = {1'b0, shifted} - {2'b00, dvs};
    q_bit   = ~diff[33];
    // A failed trial leaves shifted below the divisor, so bit 32 is zero.
    rem_nx  = q_bit ? diff[31:0] : shifted[31:0];
    dvd_nx  = {dvd[30:0], q_bit};
    q_fin   = neg_q ? -dvd_nx : dvd_nx;
    r_fin   = neg_r ? -rem_nx : rem_nx;
    // |0x80000000| is still 0x80000000 when read as unsigned, which is
    // exactly what the magnitude datapath needs.
    op1_mag = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
    op2_mag = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
  end

  assign stallreq_o = start_i & ~annul_i & (state != END);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the datapath registers (rem, dvd, dvs, signs) are not reset; they
  // are fully loaded on every issue before anything reads them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      ready_o  <= 1'b0;
      result_o <= 64'h0;
    end else if (annul_i) begin
      state   <= IDLE;
      ready_o <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (opdata2_i == 32'h0) begin
              state <= BYZERO;
            end else begin
              state <= ON;
              cnt   <= 6'd0;
              rem   <= 32'h0;
              dvd   <= op1_mag;
              dvs   <= op2_mag;
              neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
              neg_r <= signed_div_i & opdata1_i[31];
            end
          end
        end
        BYZERO: begin
          state    <= END;
          result_o <= 64'h0;
          ready_o  <= 1'b1;
        end
        ON: begin
          rem <= rem_nx;
          dvd <= dvd_nx;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state    <= END;
            result_o <= {r_fin, q_fin};
            ready_o  <= 1'b1;
          end
        end
        END: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// ---------------------------------------------------------------------------
// tb_div -- self-checking bench for div.
//
// A driver issues divisions the way the pipeline would: start_i is held
// until ready_o, and each issue pushes the expected result and the cycle it
// is due onto a scoreboard queue. A monitor pops and compares on every
// ready_o. Expected results come from 64-bit integer arithmetic on the
// operands, which truncates toward zero with a dividend-signed remainder.
// ---------------------------------------------------------------------------
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          due;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   ready_seen = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = {32'h0, a};
      y = {32'h0, b};
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: every ready_o must match the oldest outstanding expectation,
  // both in value and in the cycle it arrives.
  always @(negedge clk) begin
    if (!rst && ready_o) begin
      exp_t e;
      ready_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_result"}, result_o, e.res);
        check({e.name, "_latency"}, 64'(cyc), 64'(e.due));
      end
    end
  end

  // Caller is positioned just after a rising edge with the DUT in IDLE.
  // Leaves start_i low just after the edge that retires the instruction,
  // so an immediately following call issues back-to-back.
  task automatic run_div(input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp,
                         input string name);
    exp_t e;
    int   n_stall = 0;
    bit   got = 0;
    start_i      = 1'b1;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    e.res  = exp;
    e.due  = cyc + ((b == 32'h0) ? 2 : 33);
    e.name = name;
    exp_q.push_back(e);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (stallreq_o) n_stall++;
      if (ready_o) begin
        got = 1;
        break;
      end
    end
    check({name, "_ready_seen"}, 64'(got), 64'd1);
    check({name, "_stall_cycles"}, 64'(n_stall), (b == 32'h0) ? 64'd2 : 64'd33);
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int seen0;
    logic [31:0] a, b;
    bit sgn;

    rst = 1'b1; start_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'h0; opdata2_i = 32'h0; annul_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_result", result_o, 64'h0);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_stall", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases with hand-derived expectations.
    run_div(0, 32'd100, 32'd7, {32'd2, 32'd14}, "divu_100_7");
    run_div(1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, "div_m7_2");
    run_div(1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, "div_7_m2");
    run_div(1, 32'd5, 32'd0, 64'h0, "div_by_zero");
    run_div(1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, "div_min_m1");
    run_div(0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, "divu_max_1");
    run_div(0, 32'd3, 32'hFFFFFFFF, {32'd3, 32'h0}, "divu_3_max");

    // Annul mid-operation: issue at T, flush at T+10, then silence.
    start_i = 1'b1; signed_div_i = 1'b0;
    opdata1_i = 32'd1000; opdata2_i = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    check("annul_stall_before", 64'(stallreq_o), 64'd1);
    annul_i = 1'b1;
    #1;
    check("annul_stall_drop", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    seen0 = ready_seen;
    repeat (40) @(posedge clk);
    #1;
    check("annul_no_ready", 64'(ready_seen - seen0), 64'd0);
    run_div(0, 32'd9, 32'd2, {32'd1, 32'd4}, "divu_9_2_after_annul");

    // Reset mid-operation: all outputs zero on the following cycle.
    start_i = 1'b1; signed_div_i = 1'b0;
    opdata1_i = 32'd20; opdata2_i = 32'd3;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    start_i = 1'b0;
    @(posedge clk); #1;
    check("midrst_result", result_o, 64'h0);
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_stall", 64'(stallreq_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back: ready at T+33 and T+67.
    run_div(0, 32'd20, 32'd3, {32'd2, 32'd6}, "b2b_first");
    run_div(0, 32'd20, 32'd6, {32'd2, 32'd3}, "b2b_second");

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 100)) : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        3:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      run_div(sgn, a, b, ref_div(sgn, a, b), $sformatf("rand%0d", i));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
